// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: FSM state encodings and
// the {PCWr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush} control vectors.
package hazard_pkg;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_LD_STALL = 1'b1;

  localparam logic [3:0] CTL_RESET  = 4'b0011;
  localparam logic [3:0] CTL_NORMAL = 4'b1100;
  localparam logic [3:0] CTL_STALL  = 4'b0001;
  localparam logic [3:0] CTL_SQUASH = 4'b1111;

endpackage

// File: rtl/hazard_ctrl_dncnt.sv
// Loadable saturating down-counter with clear; clear beats load beats decrement.
module hazard_dncnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         nonzero
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // next-count selection
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, mult/div busy stalls, branch squashes.
// Optional stall performance counter enabled by defining HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRd_ID_EX,
  input  logic [REG_AW-1:0] RegisterRt_ID_EX,
  input  logic [REG_AW-1:0] RegisterRs_IF_ID,
  input  logic [REG_AW-1:0] RegisterRt_IF_ID,
  input  logic              UsesRs_IF_ID,
  input  logic              UsesRt_IF_ID,
  input  logic              MdStart_ID_EX,
  input  logic              MdUse_IF_ID,
  input  logic              BranchTaken_EX,
  output logic              PCWr,
  output logic              IF_ID_Wr,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Flush,
  output logic              md_busy,
  output logic [31:0]       stall_cycles
);

  localparam int LD_W = $clog2(LOAD_LAT + 1);
  localparam int MD_W = $clog2(MD_LAT + 1);

  logic [0:0]      state_d, state_q;
  logic [3:0]      ctl_s;
  logic            lu_hit_s, md_hit_s;
  logic            ld_clr_s, ld_load_s, ld_nz_s, md_nz_s;
  logic [LD_W-1:0] ld_cnt_s;
  logic [MD_W-1:0] md_cnt_unused_s;

  assign lu_hit_s = MemRd_ID_EX && (RegisterRt_ID_EX != '0) &&
                    ((UsesRs_IF_ID && (RegisterRs_IF_ID == RegisterRt_ID_EX)) ||
                     (UsesRt_IF_ID && (RegisterRt_IF_ID == RegisterRt_ID_EX)));
  assign md_hit_s = MdUse_IF_ID && md_nz_s;

  // priority: reset > branch squash > load stall > mult/div stall > normal
  always_comb begin
    state_d   = state_q;
    ld_clr_s  = 1'b0;
    ld_load_s = 1'b0;
    ctl_s     = CTL_NORMAL;
    if (reset) begin
      ctl_s   = CTL_RESET;
      state_d = ST_IDLE;
    end else if (BranchTaken_EX) begin
      ctl_s    = CTL_SQUASH;
      state_d  = ST_IDLE;
      ld_clr_s = 1'b1;
    end else if (state_q == ST_LD_STALL) begin
      // the load has left EX, so lu_hit is meaningless here; an empty counter also releases
      ctl_s = CTL_STALL;
      if (!ld_nz_s || (ld_cnt_s == LD_W'(1))) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_LD_STALL;
      end
    end else if (lu_hit_s) begin
      ctl_s = CTL_STALL;
      if (LOAD_LAT > 1) begin
        state_d   = ST_LD_STALL;
        ld_load_s = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (md_hit_s) begin
      ctl_s = CTL_STALL;
    end else begin
      ctl_s = CTL_NORMAL;
    end
  end

  // load-stall FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  hazard_dncnt #(.W(LD_W)) u_ld_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (ld_clr_s),
    .load     (ld_load_s),
    .load_val (LD_W'(LOAD_LAT - 1)),
    .cnt      (ld_cnt_s),
    .nonzero  (ld_nz_s)
  );

  // branches do not cancel mult/div, so this counter has no clear
  hazard_dncnt #(.W(MD_W)) u_md_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (1'b0),
    .load     (MdStart_ID_EX),
    .load_val (MD_W'(MD_LAT)),
    .cnt      (md_cnt_unused_s),
    .nonzero  (md_nz_s)
  );

  assign {PCWr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush} = ctl_s;
  assign md_busy = md_nz_s && !reset;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;

  // count every non-reset cycle with the PC held
  always_comb begin
    if (!reset && !ctl_s[3]) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // performance counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (LOAD_LAT=3 and LOAD_LAT=1, MD_LAT=4) share stimulus.
module tb_hazard_ctrl;

  localparam logic [3:0] R = 4'b0011;
  localparam logic [3:0] N = 4'b1100;
  localparam logic [3:0] S = 4'b0001;
  localparam logic [3:0] Q = 4'b1111;

  typedef struct packed {
    logic [3:0]  ctl3;
    logic        busy3;
    logic [31:0] sc3;
    logic [3:0]  ctl1;
    logic        busy1;
    logic [31:0] sc1;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       memrd, uses_rs, uses_rt, md_start, md_use, br;
  logic [4:0] rt_ex, rs_id, rt_id;

  logic       pc3, ifw3, iff3, exf3, busy3;
  logic       pc1, ifw1, iff1, exf1, busy1;
  logic [31:0] sc3, sc1;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .MD_LAT(4)) u_dut3 (
    .clk(clk), .reset(reset), .MemRd_ID_EX(memrd), .RegisterRt_ID_EX(rt_ex),
    .RegisterRs_IF_ID(rs_id), .RegisterRt_IF_ID(rt_id), .UsesRs_IF_ID(uses_rs),
    .UsesRt_IF_ID(uses_rt), .MdStart_ID_EX(md_start), .MdUse_IF_ID(md_use),
    .BranchTaken_EX(br), .PCWr(pc3), .IF_ID_Wr(ifw3), .IF_ID_Flush(iff3),
    .ID_EX_Flush(exf3), .md_busy(busy3), .stall_cycles(sc3)
  );

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .MD_LAT(4)) u_dut1 (
    .clk(clk), .reset(reset), .MemRd_ID_EX(memrd), .RegisterRt_ID_EX(rt_ex),
    .RegisterRs_IF_ID(rs_id), .RegisterRt_IF_ID(rt_id), .UsesRs_IF_ID(uses_rs),
    .UsesRt_IF_ID(uses_rt), .MdStart_ID_EX(md_start), .MdUse_IF_ID(md_use),
    .BranchTaken_EX(br), .PCWr(pc1), .IF_ID_Wr(ifw1), .IF_ID_Flush(iff1),
    .ID_EX_Flush(exf1), .md_busy(busy1), .stall_cycles(sc1)
  );

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row=%0d got=%0h expected=%0h", name, row, act, exp);
    end
  endtask

  // drive one cycle of inputs and queue the hand-computed response
  task automatic step(input logic rst, input logic mr, input logic [4:0] rte, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urs, input logic urt, input logic mds,
                      input logic mdu, input logic b,
                      input logic [3:0] c3, input logic b3, input int s3,
                      input logic [3:0] c1, input logic b1, input int s1);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; memrd = mr; rt_ex = rte; rs_id = rs; rt_id = rt;
    uses_rs = urs; uses_rt = urt; md_start = mds; md_use = mdu; br = b;
    e.ctl3 = c3; e.busy3 = b3; e.sc3 = 32'(s3);
    e.ctl1 = c1; e.busy1 = b1; e.sc1 = 32'(s1);
    exp_q.push_back(e);
  endtask

  // monitor: outputs are valid every cycle, sampled on the falling edge
  int row = 0;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ctl_lat3",  row, {28'd0, pc3, ifw3, iff3, exf3}, {28'd0, e.ctl3});
      chk("busy_lat3", row, {31'd0, busy3}, {31'd0, e.busy3});
      chk("ctl_lat1",  row, {28'd0, pc1, ifw1, iff1, exf1}, {28'd0, e.ctl1});
      chk("busy_lat1", row, {31'd0, busy1}, {31'd0, e.busy1});
`ifdef HAZARD_PERF_EN
      chk("stall_cycles_lat3", row, sc3, e.sc3);
      chk("stall_cycles_lat1", row, sc1, e.sc1);
`else
      chk("stall_cycles_lat3", row, sc3, 32'd0);
      chk("stall_cycles_lat1", row, sc1, 32'd0);
`endif
      row++;
    end
  end

  initial begin
    reset = 1'b1; memrd = 1'b0; rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    uses_rs = 1'b0; uses_rt = 1'b0; md_start = 1'b0; md_use = 1'b0; br = 1'b0;
    repeat (2) @(posedge clk);
    //    rst mr rte    rs     rt     urs   urt   mds   mdu   br     lat3          lat1
    step(1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0, R,1'b0,0,  R,1'b0,0);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0, N,1'b0,0,  N,1'b0,0);
    // load-use on rs=$8
    step(1'b0,1'b1,5'd8,5'd8,5'd0,1'b1,1'b0,1'b0,1'b0,1'b0, S,1'b0,0,  S,1'b0,0);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0, S,1'b0,1,  N,1'b0,1);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0, S,1'b0,2,  N,1'b0,1);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0, N,1'b0,3,  N,1'b0,1);
    // $0 never hazards; rt match ignored when rt unused
    step(1'b0,1'b1,5'd0,5'd0,5'd0,1'b1,1'b0,1'b0,1'b0,1'b0, N,1'b0,3,  N,1'b0,1);
    step(1'b0,1'b1,5'd9,5'd3,5'd9,1'b1,1'b0,1'b0,1'b0,1'b0, N,1'b0,3,  N,1'b0,1);
    // mult/div issue, then HI/LO reader held in ID
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b1,1'b0,1'b0, N,1'b0,3,  N,1'b0,1);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0, S,1'b1,3,  S,1'b1,1);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0, S,1'b1,4,  S,1'b1,2);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0, S,1'b1,5,  S,1'b1,3);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0, S,1'b1,6,  S,1'b1,4);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0, N,1'b0,7,  N,1'b0,5);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0, N,1'b0,7,  N,1'b0,5);
    // load-use, branch taken in the 2nd stall cycle
    step(1'b0,1'b1,5'd5,5'd0,5'd5,1'b0,1'b1,1'b0,1'b0,1'b0, S,1'b0,7,  S,1'b0,5);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b1, Q,1'b0,8,  Q,1'b0,6);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0, N,1'b0,8,  N,1'b0,6);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0, N,1'b0,8,  N,1'b0,6);
    // reset in the middle of LD_STALL and md busy
    step(1'b0,1'b1,5'd7,5'd7,5'd0,1'b1,1'b0,1'b1,1'b0,1'b0, S,1'b0,8,  S,1'b0,6);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0, S,1'b1,9,  N,1'b1,7);
    step(1'b1,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0, R,1'b0,10, R,1'b0,7);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0, N,1'b0,0,  N,1'b0,0);
    // overlapping load-use and md stall form one stream
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b1,1'b0,1'b0, N,1'b0,0,  N,1'b0,0);
    step(1'b0,1'b1,5'd4,5'd4,5'd0,1'b1,1'b0,1'b0,1'b1,1'b0, S,1'b1,0,  S,1'b1,0);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0, S,1'b1,1,  S,1'b1,1);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0, S,1'b1,2,  S,1'b1,2);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0, S,1'b1,3,  S,1'b1,3);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b1,1'b0, N,1'b0,4,  N,1'b0,4);
    step(1'b0,1'b0,5'd0,5'd0,5'd0,1'b0,1'b0,1'b0,1'b0,1'b0, N,1'b0,4,  N,1'b0,4);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS core; successor to the single-cycle load-use detector. Covers load-use stalls with configurable load latency, multi-cycle mult/div busy stalls, and taken-branch/jump squashes. Sits beside the ID stage and drives PC, IF/ID and ID/EX register enables and flushes.

Parameters:
REG_AW, 5, register-specifier width.
LOAD_LAT, 1, load-use stall cycles per hazard (>=1).
MD_LAT, 32, cycles the mult/div unit stays busy after issue (>=1).

Ports:
clk  in  1  core clock.
reset  in  1  synchronous reset, active-high.
MemRd_ID_EX  in  1  instruction in EX is a load.
RegisterRt_ID_EX  in  REG_AW  load destination in EX.
RegisterRs_IF_ID  in  REG_AW  rs of instruction in ID.
RegisterRt_IF_ID  in  REG_AW  rt of instruction in ID.
UsesRs_IF_ID  in  1  ID instruction reads rs.
UsesRt_IF_ID  in  1  ID instruction reads rt.
MdStart_ID_EX  in  1  mult/div issued into EX this cycle.
MdUse_IF_ID  in  1  ID instruction reads HI/LO or issues mult/div.
BranchTaken_EX  in  1  branch/jump in EX redirects PC.
PCWr  out  1  PC write enable.
IF_ID_Wr  out  1  IF/ID write enable.
IF_ID_Flush  out  1  bubble into IF/ID.
ID_EX_Flush  out  1  bubble into ID/EX.
md_busy  out  1  mult/div counter non-zero.
stall_cycles  out  32  performance count (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- FSM states: IDLE, LD_STALL. Separate mult/div down-counter md_cnt, width $clog2(MD_LAT+1). Load counter ld_cnt, width $clog2(LOAD_LAT+1).
- lu_hit = MemRd_ID_EX & RegisterRt_ID_EX!=0 & ((UsesRs_IF_ID & Rs==Rt_ID_EX) | (UsesRt_IF_ID & Rt==Rt_ID_EX)). Register $0 never hazards.
- md_hit = MdUse_IF_ID & md_busy. md_busy = (md_cnt!=0), registered.
- Priority, evaluated combinationally each cycle: reset > BranchTaken_EX > load stall > md stall > normal.
- Reset active: PCWr=0, IF_ID_Wr=0, IF_ID_Flush=1, ID_EX_Flush=1, md_busy=0. State=IDLE, both counters=0, stall_cycles=0. Takes effect mid-stall; next cycle is normal.
- Branch: PCWr=1, IF_ID_Wr=1, IF_ID_Flush=1, ID_EX_Flush=1. Any load stall aborts (state->IDLE, ld_cnt=0). md_cnt keeps counting.
- Load stall: PCWr=0, IF_ID_Wr=0, IF_ID_Flush=0, ID_EX_Flush=1.
  - IDLE & lu_hit: stall this cycle. If LOAD_LAT>1, go to LD_STALL with ld_cnt=LOAD_LAT-1.
  - LD_STALL: stall every cycle and decrement. At ld_cnt==1, return to IDLE next cycle.
  - Total stall is exactly LOAD_LAT cycles. lu_hit is ignored while in LD_STALL because the load has left EX.
- md stall (no higher-priority event, md_hit): same outputs as load stall.
- Normal: PCWr=1, IF_ID_Wr=1, flushes 0.
- md_cnt:
  - MdStart_ID_EX loads MD_LAT.
  - Otherwise decrements when non-zero; saturates at 0.
  - A new MdStart while busy reloads MD_LAT.
  - md_busy is asserted on the cycle after MdStart.
- Simultaneous lu_hit and md_hit: one stall stream. Release happens only when both clear.

Optional Feature:
HAZARD_PERF_EN:
- Defined: stall_cycles increments, wrapping at 2^32, on every cycle with PCWr=0 outside reset.
- Undefined: stall_cycles is tied to 0 and no counter logic is generated.

Decomposition:
- Package hazard_pkg: state enum {IDLE, LD_STALL}; localparams for reset/normal/stall/squash control vectors {PCWr, IF_ID_Wr, IF_ID_Flush, ID_EX_Flush}.
- One sub-module, hazard_dncnt: loadable saturating down-counter, parametrised width, outputs nonzero flag. Instantiated for ld_cnt and md_cnt.

Test Plan:
1. LOAD_LAT=1: load to $8 in EX, ID reads rs=$8 -> exactly 1 cycle PCWr=0, IF_ID_Wr=0, ID_EX_Flush=1, then normal.
2. LOAD_LAT=3: same hazard -> 3 consecutive stall cycles. Load to $0 with rs=$0 -> no stall. UsesRt=0 with rt match -> no stall.
3. MD_LAT=4: MdStart, then MdUse held in ID -> md_busy high 4 cycles and stall for each. PCWr returns to 1 the cycle md_busy falls.
4. LOAD_LAT=3: branch taken in the 2nd stall cycle -> that cycle PCWr=1 with both flushes=1, state IDLE, no further stalls.
5. Reset asserted mid md-busy and mid LD_STALL -> outputs take reset values that cycle. After release, md_busy=0 and normal flow.
6. HAZARD_PERF_EN defined: the scenario 2 (LOAD_LAT=3) load-use stall followed by the scenario 3 (MD_LAT=4) mult/div stall -> stall_cycles=7. Undefined -> stall_cycles=0 throughout.
